// File: rtl/compare_unit_if.sv
// Handshake bundle for compare_unit: operands and opcode in, Forth flag/result out.
interface compare_unit_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] i_a;
  logic [N-1:0] i_b;
  logic [2:0]   i_op;
  logic         o_valid;
  logic         o_ready;
  logic [N-1:0] o_result;
  logic [5:0]   o_flags;
  logic         o_busy;

  modport master (
    output i_valid, i_a, i_b, i_op, o_ready,
    input  i_ready, o_valid, o_result, o_flags, o_busy
  );

  modport slave (
    input  i_valid, i_a, i_b, i_op, o_ready,
    output i_ready, o_valid, o_result, o_flags, o_busy
  );
endinterface

// File: rtl/compare_unit.sv
// Digit-serial (MSB first, early-exit) Forth relational unit with {eq,neq,lt,lte,gt,gte} flags.
// Optional feature macro: FORTH_MINMAX_EN enables the operand mux for MIN (op 6) / MAX (op 7).
module compare_unit #(
  parameter int N = 32,
  parameter int W = 8
) (
  input logic            clk,
  input logic            rst,
  compare_unit_if.slave  bus
);
  localparam int ND = N / W;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

  if (N % W != 0) begin : g_width_check
    $error("compare_unit: N must be a multiple of W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  a_q, b_q;
  logic [2:0]    op_q;
  logic [KW-1:0] k_q;
  logic          valid_q;
  logic [N-1:0]  result_q;
  logic [5:0]    flags_q;

  logic [W-1:0]  a_dig [ND];
  logic [W-1:0]  b_dig [ND];

  // Digit 0 is the most significant slice.
  for (genvar gi = 0; gi < ND; gi++) begin : g_digit
    assign a_dig[gi] = a_q[N-1-gi*W -: W];
    assign b_dig[gi] = b_q[N-1-gi*W -: W];
  end

  logic         dig_lt, dig_gt, eq_d, scan_done, sel_flag;
  logic [5:0]   flags_d;
  logic [N-1:0] result_d;

  always_comb begin
    dig_lt    = a_dig[k_q] < b_dig[k_q];
    dig_gt    = a_dig[k_q] > b_dig[k_q];
    eq_d      = ~dig_lt & ~dig_gt;
    scan_done = dig_lt | dig_gt | (k_q == K_LAST);
    flags_d   = {eq_d, ~eq_d, dig_lt, dig_lt | eq_d, dig_gt, dig_gt | eq_d};
    sel_flag  = 1'b0;
    case (op_q)
      3'd0:    sel_flag = flags_d[5];
      3'd1:    sel_flag = flags_d[4];
      3'd2:    sel_flag = flags_d[3];
      3'd3:    sel_flag = flags_d[2];
      3'd4:    sel_flag = flags_d[1];
      3'd5:    sel_flag = flags_d[0];
      default: sel_flag = 1'b0;
    endcase
    result_d = {N{sel_flag}};
`ifdef FORTH_MINMAX_EN
    if (op_q == 3'd6) result_d = dig_lt ? a_q : b_q;
    if (op_q == 3'd7) result_d = dig_gt ? a_q : b_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            a_q     <= bus.i_a;
            b_q     <= bus.i_b;
            op_q    <= bus.i_op;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (scan_done) begin
            flags_q  <= flags_d;
            result_q <= result_d;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.o_ready) begin
            valid_q <= 1'b0;
            k_q     <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready  = (state_q == IDLE) & ~rst;
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_flags  = flags_q;
endmodule

// File: tb/tb_compare_unit.sv
// Table-driven and randomized checks of compare_unit against a numeric reference model.
module tb_compare_unit;
  localparam int N  = 32;
  localparam int W  = 8;
  localparam int ND = N / W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_unit_if #(.N(N)) bus ();
  compare_unit #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic [5:0]   f;
    logic [N-1:0] r;
    int           lat;
    int           hold;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flags from numeric ordering, latency from the first differing digit.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op,
                                output logic [5:0] f, output logic [N-1:0] r, output int lat);
    logic lt, gt, eq;
    logic [N-1:0] mask, da, db;
    lt = a < b;
    gt = a > b;
    eq = a == b;
    f = {eq, !eq, lt, lt || eq, gt, gt || eq};
    case (op)
      3'd0: r = eq ? '1 : '0;
      3'd1: r = !eq ? '1 : '0;
      3'd2: r = lt ? '1 : '0;
      3'd3: r = (lt || eq) ? '1 : '0;
      3'd4: r = gt ? '1 : '0;
      3'd5: r = (gt || eq) ? '1 : '0;
`ifdef FORTH_MINMAX_EN
      3'd6: r = lt ? a : b;
      default: r = gt ? a : b;
`else
      default: r = '0;
`endif
    endcase
    mask = (N'(1) << W) - 1;
    lat = ND + 1;
    for (int k = 0; k < ND; k++) begin
      da = (a >> (N - W * (k + 1))) & mask;
      db = (b >> (N - W * (k + 1))) & mask;
      if (da != db) begin
        lat = 2 + k;
        break;
      end
    end
  endfunction

  // Starts and ends at a negedge with the unit idle.
  task automatic run_op(input string tag, input vec_t v);
    int lat;
    int guard;
    guard = 0;
    while (!bus.i_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, " i_ready"}, bus.i_ready, 1);
    bus.i_a = v.a; bus.i_b = v.b; bus.i_op = v.op; bus.i_valid = 1'b1; bus.o_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_op = ~v.op;
    bus.i_a = $urandom;
    bus.i_b = $urandom;
    lat = 1;
    @(negedge clk);
    while (!bus.o_valid && lat < ND + 4) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " o_valid"}, bus.o_valid, 1);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " flags"}, bus.o_flags, v.f);
    chk({tag, " result"}, bus.o_result, v.r);
    for (int h = 0; h < v.hold; h++) begin
      bus.i_valid = (h == 1);
      @(negedge clk);
      chk({tag, " hold o_valid"}, bus.o_valid, 1);
      chk({tag, " hold i_ready"}, bus.i_ready, 0);
      chk({tag, " hold flags"}, bus.o_flags, v.f);
      chk({tag, " hold result"}, bus.o_result, v.r);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    @(negedge clk);
    bus.o_ready = 1'b0;
    chk({tag, " post o_valid"}, bus.o_valid, 0);
    chk({tag, " post i_ready"}, bus.i_ready, 1);
    chk({tag, " post busy"}, bus.o_busy, 0);
    $display("op %s a=%h b=%h op=%0d flags=%b result=%h lat=%0d", tag, v.a, v.b, v.op, v.f, v.r, lat);
  endtask

  initial begin
    vec_t v;
    logic seen;
    bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_op = '0; bus.o_ready = 1'b0;

    tbl.push_back('{32'h0, 32'h1, 3'd2, 6'b011100, 32'hFFFFFFFF, 5, 3});
    tbl.push_back('{32'h1, 32'h0, 3'd5, 6'b010011, 32'hFFFFFFFF, 5, 0});
    tbl.push_back('{32'hFFFFFFFF, 32'h0, 3'd0, 6'b010011, 32'h0, 2, 0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 6'b100101, 32'hFFFFFFFF, 5, 0});
    tbl.push_back('{32'hFFFFFFFE, 32'h0, 3'd4, 6'b010011, 32'hFFFFFFFF, 2, 0});
    tbl.push_back('{32'h12340000, 32'h12350000, 3'd1, 6'b011100, 32'hFFFFFFFF, 3, 0});
    tbl.push_back('{32'h55AA0010, 32'h55AA0001, 3'd3, 6'b010011, 32'h0, 5, 1});
    tbl.push_back('{32'hFFFFFFFE, 32'h0, 3'd6, 6'b010011, 32'h0, 2, 0});
`ifdef FORTH_MINMAX_EN
    tbl.push_back('{32'hFFFFFFFE, 32'h0, 3'd7, 6'b010011, 32'hFFFFFFFE, 2, 0});
    tbl.push_back('{32'h0000FF00, 32'h0000FE00, 3'd6, 6'b010011, 32'h0000FE00, 4, 0});
    tbl.push_back('{32'h00000077, 32'h00000077, 3'd7, 6'b100101, 32'h00000077, 5, 0});
`else
    tbl.push_back('{32'hFFFFFFFE, 32'h0, 3'd7, 6'b010011, 32'h0, 2, 0});
    tbl.push_back('{32'h0000FF00, 32'h0000FE00, 3'd6, 6'b010011, 32'h0, 4, 0});
    tbl.push_back('{32'h00000077, 32'h00000077, 3'd7, 6'b100101, 32'h0, 5, 0});
`endif

    repeat (3) @(negedge clk);
    chk("reset o_valid", bus.o_valid, 0);
    chk("reset o_result", bus.o_result, 0);
    chk("reset o_flags", bus.o_flags, 0);
    chk("reset o_busy", bus.o_busy, 0);
    chk("reset i_ready", bus.i_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset release i_ready", bus.i_ready, 1);
    @(negedge clk);

    foreach (tbl[i]) run_op($sformatf("vec%0d", i), tbl[i]);

    // Random operands, biased toward shared high digits so every exit point is hit.
    for (int i = 0; i < 150; i++) begin
      int sel;
      int j;
      logic [N-1:0] m;
      v.a = $urandom;
      v.b = $urandom;
      v.op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      if (sel == 0) v.b = v.a;
      else if (sel == 1) begin
        j = $urandom_range(1, ND - 1);
        m = (N'(1) << (W * j)) - 1;
        v.b = (v.a & ~m) | (v.b & m);
      end
      v.hold = $urandom_range(0, 2);
      model(v.a, v.b, v.op, v.f, v.r, v.lat);
      run_op($sformatf("rnd%0d", i), v);
    end

    // Reset while scanning: op is dropped and never produces o_valid.
    bus.i_a = 32'h0; bus.i_b = 32'h1; bus.i_op = 3'd2; bus.i_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("rstrun busy", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("rstrun i_ready in rst", bus.i_ready, 0);
    @(negedge clk);
    chk("rstrun o_valid", bus.o_valid, 0);
    chk("rstrun busy after", bus.o_busy, 0);
    rst = 1'b0;
    #1;
    chk("rstrun i_ready", bus.i_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.o_valid;
    end
    chk("rstrun no o_valid", seen, 0);
    $display("op rstrun checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
